axi4_rd_slave_mem: RTL

//  Synthesizable AXI4 read-only slave memory; consumes the AR channel driven by the axi4 BFM / core fetch port
//  and returns R-channel bursts. Sits directly downstream of the axi4 interface in the uvm_bfm bench as the

---
 rtl/axi4_rd_slave_mem_if.sv | 29 ++
 rtl/axi4_rd_slave_mem.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/axi4_rd_slave_mem_if.sv
// AXI4 read-address and read-data channel bundle for axi4_rd_slave_mem.
interface axi4_rd_slave_mem_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport slave (
    input  arid, araddr, arlen, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

  modport master (
    output arid, araddr, arlen, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi4_rd_slave_mem.sv
// AXI4 read-only slave memory: one burst in flight, optional first-beat latency,
// FIXED/INCR/WRAP addressing, SLVERR on bad bursts or out-of-range words, backdoor preload.
module axi4_rd_slave_mem #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  axi4_rd_slave_mem_if.slave       axi,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [DATA_W-1:0]        ld_data
);
  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int IW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] NB_A    = ADDR_W'(NB);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DATA
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   mask_q, mask_d;
  logic [7:0]          len_q, len_d;
  logic [1:0]          burst_q, burst_d;
  logic                berr_q, berr_d;
  logic [7:0]          beat_q, beat_d;
  logic [7:0]          wait_q, wait_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                ld_ok;
  logic                arready;
  logic                rvalid;
  logic                ar_hs;
  logic                beat_err;
  logic [ADDR_W-1:0]   word_idx;
  logic [ADDR_W-1:0]   addr_next;

  // Backdoor load; the range check only exists when DEPTH leaves unused index codes.
  if (DEPTH == (1 << IW)) begin : g_ld_full
    assign ld_ok = 1'b1;
  end else begin : g_ld_part
    assign ld_ok = ({1'b0, ld_addr} < (IW+1)'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (ld_en && ld_ok) begin
      mem[ld_addr] <= ld_data;
    end
  end

  assign arready  = (state_q == S_IDLE) && !rst;
  assign rvalid   = (state_q == S_DATA);
  assign ar_hs    = axi.arvalid && arready;
  assign word_idx = addr_q >> LB;
  assign beat_err = berr_q || (word_idx >= DEPTH_A);

  assign axi.arready = arready;
  assign axi.rvalid  = rvalid;
  assign axi.rid     = rvalid ? id_q : '0;
  assign axi.rlast   = rvalid && (beat_q == len_q);
  assign axi.rresp   = (rvalid && beat_err) ? 2'b10 : 2'b00;
  assign axi.rdata   = (rvalid && !beat_err) ? mem[word_idx[IW-1:0]] : '0;

  // WRAP keeps the bits above the wrap boundary and lets the low bits roll over.
  always_comb begin
    addr_next = addr_q + NB_A;
    case (burst_q)
      2'b00:   addr_next = addr_q;
      2'b10:   addr_next = (addr_q & ~mask_q) | ((addr_q + NB_A) & mask_q);
      default: addr_next = addr_q + NB_A;
    endcase
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    len_d   = len_q;
    burst_d = burst_q;
    berr_d  = berr_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (ar_hs) begin
          id_d    = axi.arid;
          addr_d  = axi.araddr & ~ADDR_W'(NB - 1);
          mask_d  = ADDR_W'((int'(axi.arlen) + 1) * NB - 1);
          len_d   = axi.arlen;
          burst_d = axi.arburst;
          berr_d  = (axi.arburst == 2'b11) ||
                    ((axi.arburst == 2'b10) &&
                     !(axi.arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));
          beat_d  = '0;
          if (RD_LAT > 0) begin
            state_d = S_WAIT;
            wait_d  = 8'(RD_LAT);
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_WAIT: begin
        if (wait_q <= 8'd1) begin
          state_d = S_DATA;
        end else begin
          wait_d = wait_q - 8'd1;
        end
      end
      S_DATA: begin
        if (axi.rready) begin
          beat_d = beat_q + 8'd1;
          addr_d = addr_next;
          if (beat_q == len_q) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      mask_q  <= '0;
      len_q   <= '0;
      burst_q <= '0;
      berr_q  <= 1'b0;
      beat_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      berr_q  <= berr_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
    end
  end
endmodule
